// File: rtl/function_sweeper_pkg.sv
// Shared types and constants for the exhaustive truth-table sweeper.
// FSM encoding, MISR constants and the table-depth helper live here.
package function_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // x^16 + x^12 + x^5 + 1, left-shifting form
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic int tt_depth(input int in_width);
        return 32'sd1 << in_width;
    endfunction

endpackage

// File: rtl/function_sweeper_if.sv
// Sweeper control/result bundle; master is the lab bench side, slave is the sweeper.
// The sig signal exists only when FUNC_SWEEP_SIGNATURE_EN is defined.
interface function_sweeper_if
    import function_sweeper_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 1
);
    localparam int DEPTH = tt_depth(IN_WIDTH);
    localparam int TT_W  = OUT_WIDTH * DEPTH;

    logic                 start;
    logic                 abort;
    logic [OUT_WIDTH-1:0] dut_f;
    logic [TT_W-1:0]      exp_tt;
    logic [IN_WIDTH-1:0]  vec_out;
    logic                 busy;
    logic                 done;
    logic [TT_W-1:0]      tt;
    logic [IN_WIDTH:0]    err_cnt;
    logic [IN_WIDTH-1:0]  first_fail;
    logic                 fail_vld;
`ifdef FUNC_SWEEP_SIGNATURE_EN
    logic [15:0]          sig;
`endif

    modport master (
        output start, abort, dut_f, exp_tt,
`ifdef FUNC_SWEEP_SIGNATURE_EN
        input  sig,
`endif
        input  vec_out, busy, done, tt, err_cnt, first_fail, fail_vld
    );

    modport slave (
        input  start, abort, dut_f, exp_tt,
`ifdef FUNC_SWEEP_SIGNATURE_EN
        output sig,
`endif
        output vec_out, busy, done, tt, err_cnt, first_fail, fail_vld
    );

endinterface

// File: rtl/function_sweeper_misr.sv
// 16-bit multiple-input signature register, built only under FUNC_SWEEP_SIGNATURE_EN.
// Each enabled cycle folds data into the low bits, then shifts with polynomial feedback.
module function_sweeper_misr
    import function_sweeper_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] sig
);

    logic [15:0] sig_r;
    logic [15:0] mixed_s;
    logic [15:0] next_s;

    // Fold sample into state, then one feedback shift
    always_comb begin
        mixed_s = sig_r ^ data;
        if (mixed_s[15]) begin
            next_s = {mixed_s[14:0], 1'b0} ^ MISR_POLY;
        end else begin
            next_s = {mixed_s[14:0], 1'b0};
        end
    end

    // Signature register: seed on load, advance on enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= 16'h0000;
        end else if (load) begin
            sig_r <= MISR_SEED;
        end else if (en) begin
            sig_r <= next_s;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/function_sweeper.sv
// Exhaustive stimulus/capture engine: walks every input vector, samples after SETTLE+1
// cycles, records the truth table and scores it. FUNC_SWEEP_SIGNATURE_EN adds a MISR signature.
module function_sweeper
    import function_sweeper_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 1,
    parameter int SETTLE    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    function_sweeper_if.slave bus
);

    localparam int DEPTH = tt_depth(IN_WIDTH);
    localparam int TT_W  = OUT_WIDTH * DEPTH;
    localparam int ERR_W = IN_WIDTH + 1;

    state_t               state_r;
    state_t               next_state_s;
    logic [3:0]           settle_r;
    logic [IN_WIDTH-1:0]  vec_out_r;
    logic [IN_WIDTH-1:0]  first_fail_r;
    logic [TT_W-1:0]      tt_r;
    logic [ERR_W-1:0]     err_cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 fail_vld_r;
    logic                 launch_s;
    logic                 sample_s;
    logic                 last_s;
    logic                 mismatch_s;
    int                   tt_idx_s;

    // Sweep qualifiers; abort suppresses the sample taken in the same cycle
    always_comb begin
        launch_s   = (state_r == IDLE) && bus.start;
        sample_s   = (state_r == APPLY) && !bus.abort && (settle_r == 4'(SETTLE));
        last_s     = (vec_out_r == IN_WIDTH'(DEPTH - 1));
        tt_idx_s   = int'(vec_out_r) * OUT_WIDTH;
        mismatch_s = (bus.dut_f != bus.exp_tt[tt_idx_s +: OUT_WIDTH]);
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = APPLY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    next_state_s = IDLE;
                end else if (sample_s && last_s) begin
                    next_state_s = FINISH;
                end else begin
                    next_state_s = APPLY;
                end
            end
            FINISH:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == APPLY);
            done_r  <= (next_state_s == FINISH);
        end
    end

    // Vector walk, capture and scoring; results hold outside APPLY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out_r    <= '0;
            settle_r     <= 4'd0;
            tt_r         <= '0;
            err_cnt_r    <= '0;
            first_fail_r <= '0;
            fail_vld_r   <= 1'b0;
        end else if (launch_s) begin
            vec_out_r    <= '0;
            settle_r     <= 4'd0;
            tt_r         <= '0;
            err_cnt_r    <= '0;
            first_fail_r <= '0;
            fail_vld_r   <= 1'b0;
        end else if ((state_r == APPLY) && !bus.abort) begin
            if (sample_s) begin
                settle_r <= 4'd0;
                tt_r[tt_idx_s +: OUT_WIDTH] <= bus.dut_f;
                if (mismatch_s) begin
                    if (err_cnt_r != ERR_W'(DEPTH)) begin
                        err_cnt_r <= err_cnt_r + ERR_W'(1);
                    end
                    if (!fail_vld_r) begin
                        first_fail_r <= vec_out_r;
                        fail_vld_r   <= 1'b1;
                    end
                end
                if (!last_s) begin
                    vec_out_r <= vec_out_r + IN_WIDTH'(1);
                end
            end else begin
                settle_r <= settle_r + 4'd1;
            end
        end
    end

`ifdef FUNC_SWEEP_SIGNATURE_EN
    logic [15:0] misr_data_s;

    // Zero-extend the response into the MISR input lanes
    always_comb begin
        misr_data_s = {{(16 - OUT_WIDTH){1'b0}}, bus.dut_f};
    end

    function_sweeper_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (launch_s),
        .en    (sample_s),
        .data  (misr_data_s),
        .sig   (bus.sig)
    );
`endif

    assign bus.vec_out    = vec_out_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.tt         = tt_r;
    assign bus.err_cnt    = err_cnt_r;
    assign bus.first_fail = first_fail_r;
    assign bus.fail_vld   = fail_vld_r;

endmodule
